io_port_responder: RTL and testbench
====================================

Name: io_port_responder

Overview:
- Peripheral-side responder for the CPU's port-mapped IO bus. It decodes ReadIO/WriteIO strobes with an 8-bit port address and drives the output port register.
- Buffers external input bytes in a small FIFO that the CPU pops through an input port.
- Exposes status and control ports.
- Sits between the cpu core (IO_datain, aluout, ReadIO, WriteIO) and board-level pins. It replaces ad-hoc port logic at top level.

Parameters:
- FIFO_DEPTH, 4, input FIFO entries; power of two, 2..8.
- OUT_PORT, 8'd2, port address of the output data register.
- IN_PORT, 8'd3, port address of the input FIFO pop.
- STAT_PORT, 8'd4, port address of the read-only status word.
- CTRL_PORT, 8'd5, port address of the write-only control register.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- ExternalReset  input  1  asynchronous, active-high reset.
- ReadIO  input  1  CPU IO read request; level, may be held for several cycles.
- WriteIO  input  1  CPU IO write request; level, may be held for several cycles.
- portadress  input  8  IO port address from the CPU.
- aluout  input  16  CPU write data.
- IO_datain  output  16  read data returned to the CPU.
- IO_ready  output  1  one-cycle pulse: IO_datain valid.
- in  input  8  external input byte.
- in_valid  input  1  external byte offered this cycle.
- in_ready  output  1  FIFO not full, equal to !full from registered state.
- out  output  8  output port register.
- out_strobe  output  1  one-cycle pulse when out is updated.

Behaviour:
- Reset (async, while ExternalReset=1):
  - out=0, out_strobe=0, IO_datain=0, IO_ready=0.
  - FIFO empty, count=0; overflow and underflow flags = 0.
  - in_ready=1.
- Edge detection: ReadIO and WriteIO are registered. Only the first cycle of a request counts (rd_start = ReadIO & !ReadIO_q; likewise wr_start). Holding a strobe never causes a repeated pop or write.
- Simultaneous rd_start and wr_start: the write is performed and the read is ignored; no IO_ready.
- Write decode on wr_start:
  - OUT_PORT: out <= aluout[7:0]; out_strobe=1 for the next cycle only.
  - CTRL_PORT: aluout[0]=1 clears overflow and underflow; aluout[1]=1 flushes the FIFO (count=0, pointers=0).
  - Any other port: no effect.
- Read decode on rd_start: IO_datain is registered and IO_ready pulses exactly 1 cycle after rd_start. Read latency is 1 clock.
  - IN_PORT, FIFO non-empty: IO_datain={8'd0, head}, then pop.
  - IN_PORT, FIFO empty: IO_datain=16'h0000 and underflow is set (sticky).
  - STAT_PORT: IO_datain = {8'd0, overflow, underflow, full, empty, count[3:0]}.
  - Other ports: IO_datain=16'h0000, IO_ready still pulses.
- IO_datain holds its value until the next read; it is not cleared.
- FIFO push: occurs when in_valid & in_ready.
  - in_valid while full: byte dropped, overflow set (sticky), count unchanged.
- Push and pop in the same cycle while non-empty: both occur, count unchanged.
- Pop from full plus in_valid in the same cycle: in_ready is 0 (registered full), so the byte is dropped and overflow is set.
- Flush plus push in the same cycle: flush wins, the byte is discarded, overflow is not set.
- Clear-flags in the same cycle as a new overflow or underflow event: the set wins.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH; full = (count==FIFO_DEPTH), empty = (count==0).
- Reset asserted mid-operation: all state returns to reset values immediately; a pending IO_ready or out_strobe is cancelled.

Decomposition:
- Shared package io_port_pkg holds:
  - default port-address constants;
  - status bit positions (STAT_OVF=7, STAT_UNF=6, STAT_FULL=5, STAT_EMPTY=4, STAT_CNT_LSB=0);
  - control bit positions (CTRL_CLR=0, CTRL_FLUSH=1).
- One sub-module, io_fifo: synchronous FIFO, 8-bit data, DEPTH parameter.
  - Inputs: push, pop, flush.
  - Outputs: head, count, full, empty.
  - Async active-high reset.
- Decode, edge detect and flag logic stay in io_port_responder.

Test Plan:
- Reset, then WriteIO=1 for 3 cycles with portadress=2, aluout=16'h12A5 → out=8'hA5, out_strobe high for exactly 1 cycle, no second strobe.
- Push 8'h11, 8'h22, then ReadIO port 3 twice (separate requests) → IO_datain=16'h0011 then 16'h0022, IO_ready 1 cycle after each rd_start. Following status read → 16'h0010 (empty, count 0).
- Push 5 bytes with FIFO_DEPTH=4 → in_ready=0 after the 4th; status reads 16'h00A4 (overflow, full, count 4). Write port 5 with 16'h0001 → overflow clears, status 16'h0024.
- ReadIO port 3 on an empty FIFO → IO_datain=16'h0000, status 16'h0050. A pop coinciding with a push at count=2 → count stays 2.
- ReadIO and WriteIO rising together on port 2 with aluout=16'h0033 → out=8'h33, no IO_ready. Flush via 16'h0002 while in_valid=1 → count 0, overflow 0.
- ExternalReset asserted asynchronously with a pending read and count=3 → IO_ready=0, count=0, out=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/io_port_pkg.sv
// Shared constants for the port-mapped IO responder: default port addresses,
// status/control bit positions and the status-word packing helper.
package io_port_pkg;

  localparam logic [7:0] DEF_OUT_PORT  = 8'd2;
  localparam logic [7:0] DEF_IN_PORT   = 8'd3;
  localparam logic [7:0] DEF_STAT_PORT = 8'd4;
  localparam logic [7:0] DEF_CTRL_PORT = 8'd5;

  localparam int STAT_OVF     = 7;
  localparam int STAT_UNF     = 6;
  localparam int STAT_FULL    = 5;
  localparam int STAT_EMPTY   = 4;
  localparam int STAT_CNT_LSB = 0;

  localparam int CTRL_CLR   = 0;
  localparam int CTRL_FLUSH = 1;

  function automatic logic [15:0] pack_status(input logic ovf, input logic unf,
                                              input logic full, input logic empty,
                                              input logic [3:0] cnt);
    logic [15:0] s;
    s = '0;
    s[STAT_OVF]            = ovf;
    s[STAT_UNF]            = unf;
    s[STAT_FULL]           = full;
    s[STAT_EMPTY]          = empty;
    s[STAT_CNT_LSB +: 4]   = cnt;
    return s;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Small synchronous byte FIFO with occupancy count and a flush that wins over
// any push or pop in the same cycle.
module io_fifo #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [7:0]       din,
  output logic [7:0]       head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/io_port_responder.sv
// Peripheral-side responder for the CPU IO bus: output register, input FIFO
// popped through a port, sticky status flags and a control port.
module io_port_responder
  import io_port_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] OUT_PORT   = DEF_OUT_PORT,
  parameter logic [7:0] IN_PORT    = DEF_IN_PORT,
  parameter logic [7:0] STAT_PORT  = DEF_STAT_PORT,
  parameter logic [7:0] CTRL_PORT  = DEF_CTRL_PORT
) (
  input  logic        clk,
  input  logic        ExternalReset,
  input  logic        ReadIO,
  input  logic        WriteIO,
  input  logic [7:0]  portadress,
  input  logic [15:0] aluout,
  output logic [15:0] IO_datain,
  output logic        IO_ready,
  input  logic [7:0]  in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out,
  output logic        out_strobe
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic             rd_req_p1;
  logic             wr_req_p1;
  logic             rd_start;
  logic             wr_start;
  logic             rd_go;
  logic             sel_out;
  logic             sel_in;
  logic             sel_stat;
  logic             sel_ctrl;
  logic             clr_flags;
  logic             flush;
  logic             push;
  logic             pop;
  logic             ovf_evt;
  logic             unf_evt;
  logic             overflow;
  logic             underflow;
  logic [7:0]       head;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic [15:0]      rd_data;
  logic             unused_bits;

  assign unused_bits = ^aluout[15:8];

  // Only the first cycle of a level request counts; a write masks a
  // simultaneous read.
  assign rd_start = ReadIO & ~rd_req_p1;
  assign wr_start = WriteIO & ~wr_req_p1;
  assign rd_go    = rd_start & ~wr_start;

  assign sel_out  = (portadress == OUT_PORT);
  assign sel_in   = (portadress == IN_PORT);
  assign sel_stat = (portadress == STAT_PORT);
  assign sel_ctrl = (portadress == CTRL_PORT);

  assign clr_flags = wr_start & sel_ctrl & aluout[CTRL_CLR];
  assign flush     = wr_start & sel_ctrl & aluout[CTRL_FLUSH];

  // in_ready comes from registered full, so a pop from full cannot admit a byte.
  assign in_ready = ~full;
  assign push     = in_valid & ~full & ~flush;
  assign ovf_evt  = in_valid & full & ~flush;
  assign pop      = rd_go & sel_in & ~empty;
  assign unf_evt  = rd_go & sel_in & empty;

  io_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (ExternalReset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (in),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    rd_data = '0;
    if (sel_in && !empty) begin
      rd_data = {8'd0, head};
    end else if (sel_stat) begin
      rd_data = pack_status(overflow, underflow, full, empty, 4'(count));
    end
  end

  // Stage p1: request history, read response, output register and flags.
  always_ff @(posedge clk or posedge ExternalReset) begin
    if (ExternalReset) begin
      rd_req_p1  <= 1'b0;
      wr_req_p1  <= 1'b0;
      IO_datain  <= '0;
      IO_ready   <= 1'b0;
      out        <= '0;
      out_strobe <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      rd_req_p1  <= ReadIO;
      wr_req_p1  <= WriteIO;
      IO_ready   <= rd_go;
      out_strobe <= wr_start & sel_out;
      if (rd_go) IO_datain <= rd_data;
      if (wr_start && sel_out) out <= aluout[7:0];
      overflow   <= ovf_evt | (overflow & ~clr_flags);
      underflow  <= unf_evt | (underflow & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Bench for io_port_responder: directed vector table, async-reset sequence and
// randomized traffic against a queue-based reference model.
module tb_io_port_responder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        ExternalReset;
  logic        ReadIO, WriteIO;
  logic [7:0]  portadress;
  logic [15:0] aluout;
  logic [15:0] IO_datain;
  logic        IO_ready;
  logic [7:0]  in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out;
  logic        out_strobe;

  int n_tests = 0;
  int n_fail  = 0;

  io_port_responder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .ExternalReset (ExternalReset),
    .ReadIO        (ReadIO),
    .WriteIO       (WriteIO),
    .portadress    (portadress),
    .aluout        (aluout),
    .IO_datain     (IO_datain),
    .IO_ready      (IO_ready),
    .in            (in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out           (out),
    .out_strobe    (out_strobe)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0]  m_q[$];
  logic        m_ovf, m_unf, m_prev_rd, m_prev_wr;
  logic [7:0]  m_out;
  logic        m_strb, m_rdy, m_inr;
  logic [15:0] m_din;

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_unf = 0; m_prev_rd = 0; m_prev_wr = 0;
    m_out = 0; m_strb = 0; m_rdy = 0; m_din = 0; m_inr = 1;
  endtask

  task automatic model_step(input logic rd, input logic wr, input logic [7:0] port,
                            input logic [15:0] a, input logic iv, input logic [7:0] ib);
    logic rs, ws, rgo, clr, fl, is_full, is_empty, pop_ok, push_ok, ovf_e, unf_e;
    rs = rd && !m_prev_rd;
    ws = wr && !m_prev_wr;
    m_prev_rd = rd;
    m_prev_wr = wr;
    rgo = rs && !ws;
    is_full  = (m_q.size() == DEPTH);
    is_empty = (m_q.size() == 0);
    m_strb = 0; clr = 0; fl = 0;
    if (ws && port == 8'd2) begin m_out = a[7:0]; m_strb = 1; end
    if (ws && port == 8'd5) begin clr = a[0]; fl = a[1]; end
    m_rdy = rgo;
    if (rgo) begin
      if (port == 8'd3) m_din = is_empty ? 16'h0000 : {8'h00, m_q[0]};
      else if (port == 8'd4)
        m_din = {8'h00, m_ovf, m_unf, is_full, is_empty, 4'(m_q.size())};
      else m_din = 16'h0000;
    end
    pop_ok  = rgo && port == 8'd3 && !is_empty;
    unf_e   = rgo && port == 8'd3 && is_empty;
    push_ok = iv && !is_full && !fl;
    ovf_e   = iv && is_full && !fl;
    if (fl) m_q.delete();
    else begin
      if (pop_ok) void'(m_q.pop_front());
      if (push_ok) m_q.push_back(ib);
    end
    if (clr) begin m_ovf = 0; m_unf = 0; end
    if (ovf_e) m_ovf = 1;
    if (unf_e) m_unf = 1;
    m_inr = (m_q.size() != DEPTH);
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out"},        32'(out),        32'(m_out));
    check({tag, ".out_strobe"}, 32'(out_strobe), 32'(m_strb));
    check({tag, ".IO_ready"},   32'(IO_ready),   32'(m_rdy));
    check({tag, ".IO_datain"},  32'(IO_datain),  32'(m_din));
    check({tag, ".in_ready"},   32'(in_ready),   32'(m_inr));
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [7:0] port,
                       input logic [15:0] a, input logic iv, input logic [7:0] ib);
    @(negedge clk);
    ReadIO = rd; WriteIO = wr; portadress = port; aluout = a; in_valid = iv; in = ib;
    model_step(rd, wr, port, a, iv, ib);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rd, wr;
    logic [7:0]  port;
    logic [15:0] a;
    logic        iv;
    logic [7:0]  ib;
    logic [7:0]  e_out;
    logic        e_strb, e_rdy;
    logic [15:0] e_din;
    logic        e_inr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rd, input logic wr, input logic [7:0] port,
                     input logic [15:0] a, input logic iv, input logic [7:0] ib,
                     input logic [7:0] e_out, input logic e_strb, input logic e_rdy,
                     input logic [15:0] e_din, input logic e_inr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.port = port; v.a = a; v.iv = iv; v.ib = ib;
    v.e_out = e_out; v.e_strb = e_strb; v.e_rdy = e_rdy; v.e_din = e_din; v.e_inr = e_inr;
    tbl.push_back(v);
  endtask

  initial begin
    ExternalReset = 1; ReadIO = 0; WriteIO = 0; portadress = 0; aluout = 0;
    in_valid = 0; in = 0;
    model_reset();

    //   rd wr port   aluout   iv in     out   stb rdy din      inr
    add(0, 1, 8'd2, 16'h12A5, 0, 8'h00, 8'hA5, 1, 0, 16'h0000, 1);  // write held 3 cycles
    add(0, 1, 8'd2, 16'h12A5, 0, 8'h00, 8'hA5, 0, 0, 16'h0000, 1);
    add(0, 1, 8'd2, 16'h12A5, 0, 8'h00, 8'hA5, 0, 0, 16'h0000, 1);
    add(0, 0, 8'd0, 16'h0000, 0, 8'h00, 8'hA5, 0, 0, 16'h0000, 1);
    add(0, 0, 8'd0, 16'h0000, 1, 8'h11, 8'hA5, 0, 0, 16'h0000, 1);  // push 11, 22
    add(0, 0, 8'd0, 16'h0000, 1, 8'h22, 8'hA5, 0, 0, 16'h0000, 1);
    add(1, 0, 8'd3, 16'h0000, 0, 8'h00, 8'hA5, 0, 1, 16'h0011, 1);  // pop
    add(0, 0, 8'd3, 16'h0000, 0, 8'h00, 8'hA5, 0, 0, 16'h0011, 1);
    add(1, 0, 8'd3, 16'h0000, 0, 8'h00, 8'hA5, 0, 1, 16'h0022, 1);  // pop
    add(0, 0, 8'd3, 16'h0000, 0, 8'h00, 8'hA5, 0, 0, 16'h0022, 1);
    add(1, 0, 8'd4, 16'h0000, 0, 8'h00, 8'hA5, 0, 1, 16'h0010, 1);  // status empty
    add(0, 0, 8'd4, 16'h0000, 0, 8'h00, 8'hA5, 0, 0, 16'h0010, 1);
    add(0, 0, 8'd0, 16'h0000, 1, 8'h01, 8'hA5, 0, 0, 16'h0010, 1);  // push 5 bytes
    add(0, 0, 8'd0, 16'h0000, 1, 8'h02, 8'hA5, 0, 0, 16'h0010, 1);
    add(0, 0, 8'd0, 16'h0000, 1, 8'h03, 8'hA5, 0, 0, 16'h0010, 1);
    add(0, 0, 8'd0, 16'h0000, 1, 8'h04, 8'hA5, 0, 0, 16'h0010, 0);
    add(0, 0, 8'd0, 16'h0000, 1, 8'h05, 8'hA5, 0, 0, 16'h0010, 0);
    add(0, 0, 8'd0, 16'h0000, 0, 8'h00, 8'hA5, 0, 0, 16'h0010, 0);
    add(1, 0, 8'd4, 16'h0000, 0, 8'h00, 8'hA5, 0, 1, 16'h00A4, 0);  // ovf, full, 4
    add(0, 0, 8'd0, 16'h0000, 0, 8'h00, 8'hA5, 0, 0, 16'h00A4, 0);
    add(0, 1, 8'd5, 16'h0001, 0, 8'h00, 8'hA5, 0, 0, 16'h00A4, 0);  // clear flags
    add(0, 0, 8'd0, 16'h0000, 0, 8'h00, 8'hA5, 0, 0, 16'h00A4, 0);
    add(1, 0, 8'd4, 16'h0000, 0, 8'h00, 8'hA5, 0, 1, 16'h0024, 0);
    add(0, 0, 8'd0, 16'h0000, 0, 8'h00, 8'hA5, 0, 0, 16'h0024, 0);
    add(0, 1, 8'd5, 16'h0002, 0, 8'h00, 8'hA5, 0, 0, 16'h0024, 1);  // flush
    add(0, 0, 8'd0, 16'h0000, 0, 8'h00, 8'hA5, 0, 0, 16'h0024, 1);
    add(1, 0, 8'd3, 16'h0000, 0, 8'h00, 8'hA5, 0, 1, 16'h0000, 1);  // pop empty
    add(0, 0, 8'd0, 16'h0000, 0, 8'h00, 8'hA5, 0, 0, 16'h0000, 1);
    add(1, 0, 8'd4, 16'h0000, 0, 8'h00, 8'hA5, 0, 1, 16'h0050, 1);  // unf, empty
    add(0, 0, 8'd0, 16'h0000, 0, 8'h00, 8'hA5, 0, 0, 16'h0050, 1);
    add(0, 0, 8'd0, 16'h0000, 1, 8'h77, 8'hA5, 0, 0, 16'h0050, 1);
    add(0, 0, 8'd0, 16'h0000, 1, 8'h88, 8'hA5, 0, 0, 16'h0050, 1);
    add(1, 0, 8'd3, 16'h0000, 1, 8'h99, 8'hA5, 0, 1, 16'h0077, 1);  // pop+push at 2
    add(0, 0, 8'd0, 16'h0000, 0, 8'h00, 8'hA5, 0, 0, 16'h0077, 1);
    add(1, 0, 8'd4, 16'h0000, 0, 8'h00, 8'hA5, 0, 1, 16'h0042, 1);  // count still 2
    add(0, 0, 8'd0, 16'h0000, 0, 8'h00, 8'hA5, 0, 0, 16'h0042, 1);
    add(1, 1, 8'd2, 16'h0033, 0, 8'h00, 8'h33, 1, 0, 16'h0042, 1);  // rd+wr together
    add(0, 0, 8'd0, 16'h0000, 0, 8'h00, 8'h33, 0, 0, 16'h0042, 1);
    add(0, 1, 8'd5, 16'h0003, 1, 8'hAA, 8'h33, 0, 0, 16'h0042, 1);  // flush vs push
    add(0, 0, 8'd0, 16'h0000, 0, 8'h00, 8'h33, 0, 0, 16'h0042, 1);
    add(1, 0, 8'd4, 16'h0000, 0, 8'h00, 8'h33, 0, 1, 16'h0010, 1);
    add(0, 0, 8'd0, 16'h0000, 0, 8'h00, 8'h33, 0, 0, 16'h0010, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.out", 32'(out), 32'h0);
    check("rst.out_strobe", 32'(out_strobe), 32'h0);
    check("rst.IO_ready", 32'(IO_ready), 32'h0);
    check("rst.IO_datain", 32'(IO_datain), 32'h0);
    check("rst.in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    ExternalReset = 0;

    foreach (tbl[i]) begin
      drive(tbl[i].rd, tbl[i].wr, tbl[i].port, tbl[i].a, tbl[i].iv, tbl[i].ib);
      check($sformatf("vec%0d.out", i),        32'(out),        32'(tbl[i].e_out));
      check($sformatf("vec%0d.out_strobe", i), 32'(out_strobe), 32'(tbl[i].e_strb));
      check($sformatf("vec%0d.IO_ready", i),   32'(IO_ready),   32'(tbl[i].e_rdy));
      check($sformatf("vec%0d.IO_datain", i),  32'(IO_datain),  32'(tbl[i].e_din));
      check($sformatf("vec%0d.in_ready", i),   32'(in_ready),   32'(tbl[i].e_inr));
      check_model($sformatf("vec%0d.model", i));
    end

    // Async reset with a pending read response and three bytes queued
    drive(0, 0, 8'd0, 16'h0000, 1, 8'hC1); check_model("ar.push1");
    drive(0, 0, 8'd0, 16'h0000, 1, 8'hC2); check_model("ar.push2");
    drive(0, 0, 8'd0, 16'h0000, 1, 8'hC3); check_model("ar.push3");
    drive(1, 0, 8'd3, 16'h0000, 0, 8'h00);
    check("ar.ready_before", 32'(IO_ready), 32'h1);
    #2;
    ExternalReset = 1;
    ReadIO = 0;
    #1;
    check("ar.IO_ready", 32'(IO_ready), 32'h0);
    check("ar.out", 32'(out), 32'h0);
    check("ar.out_strobe", 32'(out_strobe), 32'h0);
    check("ar.IO_datain", 32'(IO_datain), 32'h0);
    check("ar.in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    ExternalReset = 0;
    model_reset();
    drive(0, 0, 8'd0, 16'h0000, 0, 8'h00); check_model("ar.idle");
    drive(1, 0, 8'd4, 16'h0000, 0, 8'h00); check_model("ar.stat");
    check("ar.stat_after_reset", 32'(IO_datain), 32'h0010);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      logic        r_rd, r_wr, r_iv;
      logic [7:0]  r_port, r_ib;
      logic [15:0] r_a;
      int          sel;
      r_rd = ($urandom_range(0, 2) == 0);
      r_wr = ($urandom_range(0, 4) == 0);
      sel  = $urandom_range(0, 9);
      case (sel)
        0, 1:    r_port = 8'd2;
        2, 3, 4: r_port = 8'd3;
        5, 6:    r_port = 8'd4;
        7:       r_port = 8'd5;
        default: r_port = 8'($urandom);
      endcase
      r_a  = 16'($urandom);
      if (r_port == 8'd5 && $urandom_range(0, 1) == 0) r_a[1] = 1'b0;
      r_iv = ($urandom_range(0, 2) != 0);
      r_ib = 8'($urandom);
      drive(r_rd, r_wr, r_port, r_a, r_iv, r_ib);
      check_model($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
